wb_initiator: RTL and testbench

Wishbone classic single-transfer initiator: accepts one read/write command at a time on a valid/ready port, runs it as a WB cycle against a responder such as the user-area counter slave, and returns read data or a timeout error on a held response port. It sits between a control source (LA probes or a small sequencer) and the wishbone slave port of a user block, so the design can drive its own slaves without the management SoC. Per-transaction and timeout statistics are kept for debug visibility.

---
 rtl/wb_initiator.sv | 102 ++++++++++
 tb/tb_wb_initiator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one command in flight, registered
// WB outputs, bounded wait for ack, response held on a valid/ready port.
module wb_initiator #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [3:0]  cmd_sel,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic [15:0] txn_count,
   output logic [7:0]  timeout_count,
   output logic [1:0]  state_dbg
);

   // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready;
   // a response transfers on an edge where rsp_valid && rsp_ready. Both
   // ready/valid outputs are pure decodes of the state register.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] wait_cnt;

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign wbm_cyc_o = (state == BUS);
   assign wbm_stb_o = (state == BUS);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= 8'd0;
         rsp_dat       <= 32'd0;
         rsp_err       <= 1'b0;
         wbm_we_o      <= 1'b0;
         wbm_sel_o     <= 4'd0;
         wbm_adr_o     <= 32'd0;
         wbm_dat_o     <= 32'd0;
         txn_count     <= 16'd0;
         timeout_count <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  wbm_we_o  <= cmd_we;
                  wbm_sel_o <= cmd_sel;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  wait_cnt  <= 8'd0;
                  state     <= BUS;
               end
            end
            BUS: begin
               // Ack takes priority over a timeout landing on the same edge.
               if (wbm_ack_i) begin
                  rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                  rsp_err   <= 1'b0;
                  txn_count <= txn_count + 16'd1;
                  state     <= RESP;
               end else if (wait_cnt == LAST_WAIT) begin
                  rsp_dat   <= 32'd0;
                  rsp_err   <= 1'b1;
                  txn_count <= txn_count + 16'd1;
                  if (timeout_count != 8'hFF)
                     timeout_count <= timeout_count + 8'd1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: scripted responder, response scoreboard and
// strobe-length monitor running independently of the stimulus thread.
module tb_wb_initiator;

   localparam int TO = 4;
   localparam int RW = 32 + 1 + 16 + 8;

   logic        clk;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [3:0]  cmd_sel;
   logic [31:0] cmd_adr, cmd_dat;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_dat;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i;
   logic [15:0] txn_count;
   logic [7:0]  timeout_count;
   logic [1:0]  state_dbg;

   int checks = 0;
   int failures = 0;

   logic [RW-1:0] exp_q[$];
   int            exp_len_q[$];

   // responder controls
   int          resp_lat = 0;
   logic [31:0] resp_data = 32'd0;
   logic        ack_r = 1'b0;
   logic [31:0] dat_r = 32'd0;
   logic        late_ack = 1'b0;
   int          stb_cnt = 0;

   // expected WB outputs for the command in flight
   logic        cur_we = 1'b0;
   logic [3:0]  cur_sel = 4'd0;
   logic [31:0] cur_adr = 32'd0, cur_dat = 32'd0;

   assign wbm_ack_i = ack_r | late_ack;
   assign wbm_dat_i = late_ack ? 32'hBAD0_BAD0 : dat_r;

   wb_initiator #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_err(rsp_err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
      .txn_count(txn_count), .timeout_count(timeout_count),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // responder: ack asserted during the resp_lat-th strobe cycle (0 = never)
   initial begin
      forever begin
         @(posedge clk); #1;
         if (wbm_stb_o === 1'b1) stb_cnt++;
         else stb_cnt = 0;
         if (wbm_stb_o === 1'b1 && resp_lat != 0 && stb_cnt == resp_lat) begin
            ack_r = 1'b1;
            dat_r = resp_data;
         end else begin
            ack_r = 1'b0;
            dat_r = 32'd0;
         end
      end
   end

   // response scoreboard
   initial begin
      logic [RW-1:0] e;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp: got dat=0x%0h err=%0b expected no response", rsp_dat, rsp_err);
            end else begin
               e = exp_q.pop_front();
               check("rsp_dat", 64'(rsp_dat), 64'(e[RW-1 -: 32]));
               check("rsp_err", 64'(rsp_err), 64'(e[24]));
               check("txn_count", 64'(txn_count), 64'(e[23:8]));
               check("timeout_count", 64'(timeout_count), 64'(e[7:0]));
            end
         end
      end
   end

   // strobe monitor: length of each strobe burst and WB outputs while it is high
   initial begin
      int len;
      len = 0;
      forever begin
         @(negedge clk);
         if (wbm_stb_o === 1'b1) begin
            len++;
            if (len == 1) begin
               check("wb_cyc_eq_stb", 64'(wbm_cyc_o), 64'd1);
               check("wb_we", 64'(wbm_we_o), 64'(cur_we));
               check("wb_sel", 64'(wbm_sel_o), 64'(cur_sel));
               check("wb_adr", 64'(wbm_adr_o), 64'(cur_adr));
               check("wb_dat", 64'(wbm_dat_o), 64'(cur_dat));
            end
         end else if (len > 0) begin
            if (exp_len_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL stb_len: got burst of %0d expected no burst", len);
            end else begin
               check("stb_len", 64'(len), 64'(exp_len_q.pop_front()));
            end
            len = 0;
         end
      end
   end

   // driver tasks
   task automatic send_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input int lat, input logic [31:0] rdata,
                           input bit push_rsp, input logic [31:0] e_dat, input logic e_err,
                           input logic [15:0] e_txn, input logic [7:0] e_to, input int e_len);
      int n;
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL cmd_ready_wait: got cmd_ready=%0b expected 1 within 50 cycles", cmd_ready);
      end
      resp_lat  = lat;
      resp_data = rdata;
      cur_we = we; cur_sel = sel; cur_adr = adr; cur_dat = dat;
      if (push_rsp) exp_q.push_back({e_dat, e_err, e_txn, e_to});
      exp_len_q.push_back(e_len);
      cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (rsp_valid !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL rsp_wait: got rsp_valid=%0b expected 1 within 50 cycles", rsp_valid);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || exp_len_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d rsp / %0d bursts pending expected 0", exp_q.size(), exp_len_q.size());
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'd0;
      cmd_adr = 32'd0; cmd_dat = 32'd0; rsp_ready = 1'b1;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
      check("rst_cyc_stb_we", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'd0);
      check("rst_sel", 64'(wbm_sel_o), 64'd0);
      check("rst_adr", 64'(wbm_adr_o), 64'd0);
      check("rst_wdat", 64'(wbm_dat_o), 64'd0);
      check("rst_txn", 64'(txn_count), 64'd0);
      check("rst_to", 64'(timeout_count), 64'd0);
      reset = 1'b0;

      // write, ack after one registered responder cycle
      send_cmd(1'b1, 4'h3, 32'h3000_0000, 32'h0000_00A5, 2, 32'hFFFF_FFFF,
               1'b1, 32'd0, 1'b0, 16'd1, 8'd0, 2);
      wait_drain();

      // read, response held with rsp_ready low for 3 cycles
      @(posedge clk); #1 rsp_ready = 1'b0;
      send_cmd(1'b0, 4'hF, 32'h3000_0004, 32'h0, 2, 32'h0000_1234,
               1'b1, 32'h0000_1234, 1'b0, 16'd2, 8'd0, 2);
      wait_rsp();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
         check("hold_rsp_dat", 64'(rsp_dat), 64'h1234);
         check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_drain();

      // timeout with a late ack while the response is held
      @(posedge clk); #1 rsp_ready = 1'b0;
      send_cmd(1'b0, 4'hF, 32'h3000_0008, 32'h0, 0, 32'h0,
               1'b1, 32'd0, 1'b1, 16'd3, 8'd1, TO);
      wait_rsp();
      repeat (2) @(posedge clk);
      @(negedge clk) late_ack = 1'b1;
      @(negedge clk) late_ack = 1'b0;
      @(negedge clk);
      check("late_ack_rsp_dat", 64'(rsp_dat), 64'd0);
      check("late_ack_rsp_err", 64'(rsp_err), 64'd1);
      check("late_ack_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      wait_drain();

      // ack on the final timeout cycle wins
      send_cmd(1'b0, 4'h1, 32'h3000_000C, 32'h0, TO, 32'hDEAD_BEEF,
               1'b1, 32'hDEAD_BEEF, 1'b0, 16'd4, 8'd1, TO);
      wait_drain();

      // reset during the 2nd strobe cycle
      send_cmd(1'b1, 4'hC, 32'h3000_0010, 32'h5555_AAAA, 0, 32'h0,
               1'b0, 32'd0, 1'b0, 16'd0, 8'd0, 2);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("busrst_stb", 64'(wbm_stb_o), 64'd0);
      check("busrst_cyc", 64'(wbm_cyc_o), 64'd0);
      check("busrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("busrst_txn", 64'(txn_count), 64'd0);
      check("busrst_to", 64'(timeout_count), 64'd0);
      check("busrst_cmd_ready", 64'(cmd_ready), 64'd1);
      reset = 1'b0;
      wait_drain();

      // normal write after reset
      send_cmd(1'b1, 4'h8, 32'h3000_0020, 32'h1357_9BDF, 3, 32'hFFFF_FFFF,
               1'b1, 32'd0, 1'b0, 16'd1, 8'd0, 3);
      wait_drain();

      repeat (5) @(negedge clk);
      check("final_rsp_valid", 64'(rsp_valid), 64'd0);
      check("final_cmd_ready", 64'(cmd_ready), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
